// File: rtl/v810_bus_pkg.sv
// Shared types and helpers for the v810 data-bus memory target:
// FSM state encoding, RW polarity, lane count and the address decoder.
package v810_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAITS = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam int   LANES    = 4;

  function automatic logic decode_hit(input logic [31:0] a,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return (a & mask) == base;
  endfunction

endpackage

// File: rtl/v810_mem_target_if.sv
// v810 data-bus signals between the CPU (master) and a memory target (slave).
// Handshake: a cycle starts when BCYSTn=0 and MRQn=0 are sampled on a CE edge;
// it completes in the single CE cycle where READYn=0, with D_O valid while D_OE=1.
interface v810_mem_target_if;
  logic [31:0] A;
  logic [31:0] D_I;
  logic [31:0] D_O;
  logic        D_OE;
  logic [3:0]  BEn;
  logic        RW;
  logic        MRQn;
  logic        DAn;
  logic        BCYSTn;
  logic        READYn;

  modport master (
    output A, D_I, BEn, RW, MRQn, DAn, BCYSTn,
    input  D_O, D_OE, READYn
  );

  modport slave (
    input  A, D_I, BEn, RW, MRQn, DAn, BCYSTn,
    output D_O, D_OE, READYn
  );
endinterface

// File: rtl/v810_mem_array.sv
// 2**AW x 32 single-port synchronous RAM with per-lane active-high write enables.
// Contents are never reset; only the read-data register is.
module v810_mem_array
  import v810_bus_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [AW-1:0]    i_addr,
  input  logic [31:0]      i_wdata,
  input  logic [LANES-1:0] i_we,
  input  logic             i_re,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [2**AW];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int n = 0; n < LANES; n++) begin
      if (i_we[n]) r_mem[i_addr][8*n +: 8] <= i_wdata[8*n +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= 32'h0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/v810_mem_target.sv
// v810 data-bus memory target: decodes CPU bus cycles, inserts WAIT wait states, acks with READYn.
// Optional write protect (WP input, sticky WPV flag) is built when V810_MEM_TARGET_WP_EN is defined.
module v810_mem_target
  import v810_bus_pkg::*;
#(
  parameter int          AW       = 10,
  parameter int          WAIT     = 1,
  parameter logic [31:0] SEL_BASE = 32'h0000_0000,
  parameter logic [31:0] SEL_MASK = 32'hFFFF_F000
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic                CE,
  v810_mem_target_if.slave    bus,
`ifdef V810_MEM_TARGET_WP_EN
  input  logic                WP,
  output logic                WPV,
`endif
  output state_e              o_dbg_state
);

  localparam logic [3:0] WAIT_L = 4'(WAIT);

  state_e           r_state;
  logic [3:0]       r_cnt;
  logic             r_ready_n;
  logic             r_oe;
  logic [AW-1:0]    r_addr;
  logic             r_rw;
  logic [LANES-1:0] r_ben;
  logic [31:0]      r_wdata;

  logic             w_start;
  logic             w_take;
  logic             w_enter_ack;
  logic [AW-1:0]    w_addr;
  logic             w_rw;
  logic [LANES-1:0] w_ben;
  logic [31:0]      w_wdata;
  logic             w_rd;
  logic             w_wr;
  logic             w_wp;
  logic [LANES-1:0] w_we;
  logic [31:0]      w_rdata;

  assign w_start = !bus.BCYSTn && !bus.MRQn && decode_hit(bus.A, SEL_BASE, SEL_MASK);
  assign w_take  = CE && w_start && (r_state == ST_IDLE || r_state == ST_ACK);

  // With WAIT=0 the array is accessed on the start edge, so use the live bus fields.
  assign w_enter_ack = (w_take && WAIT_L == 4'd0) ||
                       (CE && r_state == ST_WAITS && !bus.DAn && r_cnt == 4'd1);
  assign w_addr  = w_take ? bus.A[AW+1:2] : r_addr;
  assign w_rw    = w_take ? bus.RW        : r_rw;
  assign w_ben   = w_take ? bus.BEn       : r_ben;
  assign w_wdata = w_take ? bus.D_I       : r_wdata;

  assign w_rd = w_enter_ack && (w_rw == RW_READ);
  assign w_wr = w_enter_ack && (w_rw == RW_WRITE);
  assign w_we = (w_wr && !w_wp) ? ~w_ben : '0;

`ifdef V810_MEM_TARGET_WP_EN
  logic r_wpv;
  assign w_wp = WP;
  assign WPV  = r_wpv;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES)              r_wpv <= 1'b0;
    else if (w_wr && w_wp) r_wpv <= 1'b1;
  end
`else
  assign w_wp = 1'b0;
`endif

  v810_mem_array #(.AW(AW)) u_array (
    .i_clk   (CLK),
    .i_rst   (RES),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_we    (w_we),
    .i_re    (w_rd),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_ready_n <= 1'b1;
      r_oe      <= 1'b0;
      r_addr    <= '0;
      r_rw      <= RW_READ;
      r_ben     <= '1;
      r_wdata   <= 32'h0;
    end else if (CE) begin
      case (r_state)
        // ACK shares IDLE's start logic so back-to-back cycles lose no edge.
        ST_IDLE, ST_ACK: begin
          r_state   <= ST_IDLE;
          r_ready_n <= 1'b1;
          r_oe      <= 1'b0;
          if (w_start) begin
            r_addr  <= bus.A[AW+1:2];
            r_rw    <= bus.RW;
            r_ben   <= bus.BEn;
            r_wdata <= bus.D_I;
            r_cnt   <= WAIT_L;
            if (WAIT_L == 4'd0) begin
              r_state   <= ST_ACK;
              r_ready_n <= 1'b0;
              r_oe      <= (bus.RW == RW_READ);
            end else begin
              r_state <= ST_WAITS;
            end
          end
        end
        ST_WAITS: begin
          if (bus.DAn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state   <= ST_ACK;
              r_ready_n <= 1'b0;
              r_oe      <= (r_rw == RW_READ);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.READYn  = r_ready_n;
  assign bus.D_OE    = r_oe;
  assign bus.D_O     = w_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_v810_mem_target.sv
// Directed self-checking bench for v810_mem_target (WAIT=1 main instance, WAIT=2 for CE gating).
// Exercises write protect as well when V810_MEM_TARGET_WP_EN is defined.
module tb_v810_mem_target;
  import v810_bus_pkg::*;

  logic   CLK;
  logic   RES;
  logic   CE;
  state_e dbg_state;
  state_e dbg_state2;
  int     tests_run;
  int     tests_failed;

  v810_mem_target_if bus();
  v810_mem_target_if bus2();

`ifdef V810_MEM_TARGET_WP_EN
  logic WP;
  logic WPV;
  logic WPV2;
`endif

  v810_mem_target #(.WAIT(1)) u_dut (
    .CLK         (CLK),
    .RES         (RES),
    .CE          (CE),
    .bus         (bus),
`ifdef V810_MEM_TARGET_WP_EN
    .WP          (WP),
    .WPV         (WPV),
`endif
    .o_dbg_state (dbg_state)
  );

  v810_mem_target #(.WAIT(2)) u_dut2 (
    .CLK         (CLK),
    .RES         (RES),
    .CE          (CE),
    .bus         (bus2),
`ifdef V810_MEM_TARGET_WP_EN
    .WP          (WP),
    .WPV         (WPV2),
`endif
    .o_dbg_state (dbg_state2)
  );

  // Clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.BCYSTn = 1'b1; bus.MRQn = 1'b1; bus.DAn = 1'b1; bus.RW = RW_READ;
    bus.A = 32'h0; bus.D_I = 32'h0; bus.BEn = 4'hF;
    bus2.BCYSTn = 1'b1; bus2.MRQn = 1'b1; bus2.DAn = 1'b1; bus2.RW = RW_READ;
    bus2.A = 32'h0; bus2.D_I = 32'h0; bus2.BEn = 4'hF;
  endtask

  // Driver: full cycle on the WAIT=1 instance; t_idx is the T-cycle where READYn=0 (0 = never).
  task automatic do_cycle(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ben,
                          input logic rw, output logic [31:0] rd, output logic oe, output int t_idx);
    bus.A = addr; bus.D_I = wd; bus.BEn = ben; bus.RW = rw;
    bus.MRQn = 1'b0; bus.DAn = 1'b0; bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
    t_idx = 0; rd = 32'hx; oe = 1'bx;
    for (int c = 2; c <= 20; c++) begin
      if (bus.READYn === 1'b0) begin
        t_idx = c; rd = bus.D_O; oe = bus.D_OE;
        break;
      end
      tick();
    end
    bus.MRQn = 1'b1; bus.DAn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RES = 1'b1;
    repeat (3) tick();
    RES = 1'b0;
    tick();
    tests_run++;
    if (bus.READYn !== 1'b1) begin tests_failed++; $display("FAIL reset_readyn got=%b exp=1", bus.READYn); end
    tests_run++;
    if (bus.D_OE !== 1'b0) begin tests_failed++; $display("FAIL reset_doe got=%b exp=0", bus.D_OE); end
    tests_run++;
    if (bus.D_O !== 32'h0) begin tests_failed++; $display("FAIL reset_do got=%h exp=00000000", bus.D_O); end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
`ifdef V810_MEM_TARGET_WP_EN
    tests_run++;
    if (WPV !== 1'b0) begin tests_failed++; $display("FAIL reset_wpv got=%b exp=0", WPV); end
`endif
  endtask

  task automatic test_wait1();
    logic [31:0] rd; logic oe; int t;
    do_cycle(32'h0000_0010, 32'hDEAD_BEEF, 4'b0000, RW_WRITE, rd, oe, t);
    tests_run++;
    if (t !== 3) begin tests_failed++; $display("FAIL wait1_write_latency got=T%0d exp=T3", t); end
    do_cycle(32'h0000_0010, 32'h0, 4'b0000, RW_READ, rd, oe, t);
    tests_run++;
    if (t !== 3) begin tests_failed++; $display("FAIL wait1_read_latency got=T%0d exp=T3", t); end
    tests_run++;
    if (rd !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wait1_read_data got=%h exp=deadbeef", rd); end
    tests_run++;
    if (oe !== 1'b1) begin tests_failed++; $display("FAIL wait1_read_oe got=%b exp=1", oe); end
    tests_run++;
    if (bus.D_OE !== 1'b0 || bus.READYn !== 1'b1) begin
      tests_failed++; $display("FAIL wait1_after_ack got oe=%b readyn=%b exp oe=0 readyn=1", bus.D_OE, bus.READYn);
    end
    tests_run++;
    if (bus.D_O !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL wait1_do_hold got=%h exp=deadbeef", bus.D_O); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; logic oe; int t;
    do_cycle(32'h0000_0010, 32'h1122_3344, 4'b1010, RW_WRITE, rd, oe, t);
    do_cycle(32'h0000_0012, 32'h0, 4'b0000, RW_READ, rd, oe, t);
    tests_run++;
    if (rd !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL byte_lanes got=%h exp=de22be44", rd); end
  endtask

  task automatic test_miss();
    logic [31:0] rd; logic oe; int t; int lows;
    do_cycle(32'h0000_0000, 32'h1234_5678, 4'b0000, RW_WRITE, rd, oe, t);
    bus.A = 32'h0000_2000; bus.D_I = 32'hCAFE_F00D; bus.BEn = 4'b0000; bus.RW = RW_WRITE;
    bus.MRQn = 1'b0; bus.DAn = 1'b0; bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.READYn !== 1'b1) lows++;
      tick();
    end
    bus.MRQn = 1'b1; bus.DAn = 1'b1;
    tests_run++;
    if (lows !== 0) begin tests_failed++; $display("FAIL miss_readyn got=%0d low cycles exp=0", lows); end
    do_cycle(32'h0000_0000, 32'h0, 4'b0000, RW_READ, rd, oe, t);
    tests_run++;
    if (rd !== 32'h1234_5678) begin tests_failed++; $display("FAIL miss_mem_unchanged got=%h exp=12345678", rd); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic oe; int t; int lows;
    bus.A = 32'h0000_0010; bus.D_I = 32'h0; bus.BEn = 4'b0000; bus.RW = RW_WRITE;
    bus.MRQn = 1'b0; bus.DAn = 1'b0; bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
    bus.DAn = 1'b1;
    lows = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (bus.READYn !== 1'b1) lows++;
    end
    bus.MRQn = 1'b1;
    tests_run++;
    if (lows !== 0) begin tests_failed++; $display("FAIL abort_readyn got=%0d low cycles exp=0", lows); end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin tests_failed++; $display("FAIL abort_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    do_cycle(32'h0000_0010, 32'h0, 4'b0000, RW_READ, rd, oe, t);
    tests_run++;
    if (rd !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL abort_no_write got=%h exp=de22be44", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic oe; int t;
    // Reset during WAITS discards the pending write.
    bus.A = 32'h0000_0010; bus.D_I = 32'hAAAA_AAAA; bus.BEn = 4'b0000; bus.RW = RW_WRITE;
    bus.MRQn = 1'b0; bus.DAn = 1'b0; bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
    tests_run++;
    if (dbg_state !== ST_WAITS) begin tests_failed++; $display("FAIL rst_waits_pre got=%0d exp=%0d", dbg_state, ST_WAITS); end
    #2 RES = 1'b1;
    #1;
    tests_run++;
    if (dbg_state !== ST_IDLE || bus.READYn !== 1'b1) begin
      tests_failed++; $display("FAIL rst_waits_async got state=%0d readyn=%b exp state=0 readyn=1", dbg_state, bus.READYn);
    end
    #2 RES = 1'b0;
    bus.MRQn = 1'b1; bus.DAn = 1'b1;
    repeat (3) tick();
    do_cycle(32'h0000_0010, 32'h0, 4'b0000, RW_READ, rd, oe, t);
    tests_run++;
    if (rd !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL rst_discard_write got=%h exp=de22be44", rd); end
    // Reset during ACK releases READYn/D_OE without waiting for a clock edge.
    bus.A = 32'h0000_0010; bus.RW = RW_READ; bus.BEn = 4'b0000;
    bus.MRQn = 1'b0; bus.DAn = 1'b0; bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
    tick();
    tests_run++;
    if (bus.READYn !== 1'b0) begin tests_failed++; $display("FAIL rst_ack_pre got readyn=%b exp=0", bus.READYn); end
    #2 RES = 1'b1;
    #1;
    tests_run++;
    if (bus.READYn !== 1'b1 || bus.D_OE !== 1'b0 || bus.D_O !== 32'h0) begin
      tests_failed++; $display("FAIL rst_ack_async got readyn=%b oe=%b do=%h exp 1 0 00000000", bus.READYn, bus.D_OE, bus.D_O);
    end
    #2 RES = 1'b0;
    bus.MRQn = 1'b1; bus.DAn = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    bus.A = 32'h0000_0020; bus.D_I = 32'h55AA_55AA; bus.BEn = 4'b0000; bus.RW = RW_WRITE;
    bus.MRQn = 1'b0; bus.DAn = 1'b0; bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
    tick();
    tests_run++;
    if (bus.READYn !== 1'b0) begin tests_failed++; $display("FAIL b2b_write_ack got readyn=%b exp=0", bus.READYn); end
    bus.RW = RW_READ; bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
    tests_run++;
    if (bus.READYn !== 1'b1 || dbg_state !== ST_WAITS) begin
      tests_failed++; $display("FAIL b2b_second_start got readyn=%b state=%0d exp readyn=1 state=%0d", bus.READYn, dbg_state, ST_WAITS);
    end
    tick();
    tests_run++;
    if (bus.READYn !== 1'b0 || bus.D_O !== 32'h55AA_55AA) begin
      tests_failed++; $display("FAIL b2b_read got readyn=%b do=%h exp readyn=0 do=55aa55aa", bus.READYn, bus.D_O);
    end
    bus.MRQn = 1'b1; bus.DAn = 1'b1;
    tick();
  endtask

  task automatic test_ce_gating();
    logic ce_seq [6];
    logic exp_rdy [6];
    ce_seq  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    CE = 1'b1;
    bus2.A = 32'h0000_0040; bus2.D_I = 32'h0F0F_0F0F; bus2.BEn = 4'b0000; bus2.RW = RW_WRITE;
    bus2.MRQn = 1'b0; bus2.DAn = 1'b0; bus2.BCYSTn = 1'b0;
    tick();
    bus2.BCYSTn = 1'b1;
    tests_run++;
    if (bus2.READYn !== 1'b1) begin tests_failed++; $display("FAIL ce_t1 got readyn=%b exp=1", bus2.READYn); end
    for (int i = 0; i < 6; i++) begin
      CE = ce_seq[i];
      tick();
      tests_run++;
      if (bus2.READYn !== exp_rdy[i]) begin
        tests_failed++; $display("FAIL ce_step%0d got readyn=%b exp=%b", i, bus2.READYn, exp_rdy[i]);
      end
    end
    CE = 1'b1;
    bus2.MRQn = 1'b1; bus2.DAn = 1'b1;
    tick();
  endtask

`ifdef V810_MEM_TARGET_WP_EN
  task automatic test_wp();
    logic [31:0] rd; logic oe; int t;
    WP = 1'b1;
    do_cycle(32'h0000_0010, 32'h0BAD_F00D, 4'b0000, RW_WRITE, rd, oe, t);
    tests_run++;
    if (t !== 3) begin tests_failed++; $display("FAIL wp_ack got=T%0d exp=T3", t); end
    tests_run++;
    if (WPV !== 1'b1) begin tests_failed++; $display("FAIL wp_wpv_set got=%b exp=1", WPV); end
    WP = 1'b0;
    do_cycle(32'h0000_0010, 32'h0, 4'b0000, RW_READ, rd, oe, t);
    tests_run++;
    if (rd !== 32'hDE22_BE44) begin tests_failed++; $display("FAIL wp_data_kept got=%h exp=de22be44", rd); end
    tests_run++;
    if (WPV !== 1'b1) begin tests_failed++; $display("FAIL wp_wpv_sticky got=%b exp=1", WPV); end
  endtask
`endif

  initial begin
    tests_run = 0;
    tests_failed = 0;
    RES = 1'b1;
    CE = 1'b1;
`ifdef V810_MEM_TARGET_WP_EN
    WP = 1'b0;
`endif
    bus_idle();
    test_reset();
    test_wait1();
    test_byte_lanes();
    test_miss();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_ce_gating();
`ifdef V810_MEM_TARGET_WP_EN
    test_wp();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
